// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller.
// Walks FETCH -> DECODE -> EXE -> (MEM) -> (WB) and drives the datapath
// selects and write enables for each state. It also runs the req/ready
// handshake with the shared instruction/data memory port, and aborts to
// FETCH with a bus_err pulse if the memory does not answer in time.
module mc_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWr,
  output logic       PCWr,
  output logic [1:0] NPCOp,
  output logic [1:0] EOp,
  output logic [1:0] ALUOp,
  output logic       ALUSrc,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       bus_err,
  output logic       illegal,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       bus_err_q, bus_err_d;
  logic       illegal_q, illegal_d;

  // Instruction decode straight from the IR fields
  logic i_addu, i_subu, i_jr, i_ori, i_lw, i_sw, i_beq, i_lui, i_j, i_jal;
  logic i_rarith, i_goes_exe;

  assign i_addu     = (opcode == OP_R) && (funct == FN_ADDU);
  assign i_subu     = (opcode == OP_R) && (funct == FN_SUBU);
  assign i_jr       = (opcode == OP_R) && (funct == FN_JR);
  assign i_ori      = (opcode == OP_ORI);
  assign i_lw       = (opcode == OP_LW);
  assign i_sw       = (opcode == OP_SW);
  assign i_beq      = (opcode == OP_BEQ);
  assign i_lui      = (opcode == OP_LUI);
  assign i_j        = (opcode == OP_J);
  assign i_jal      = (opcode == OP_JAL);
  assign i_rarith   = i_addu | i_subu;
  assign i_goes_exe = i_rarith | i_ori | i_lui | i_lw | i_sw | i_beq;

  // A memory wait that has used up its budget with no ready in sight
  logic timed_out;
  assign timed_out = ((state_q == S_FETCH) || (state_q == S_MEM)) &&
                     !mem_ready && (cnt_q == TIMEOUT_C);

  // Unmasked output values; forced low below while reset is asserted
  logic       mem_req_c, mem_we_c, iord_c, irwr_c, pcwr_c, alusrc_c, regwr_c;
  logic [1:0] npcop_c, eop_c, aluop_c, regdst_c, memtoreg_c;

  // ALU/extender selects: set in EXE and held through MEM and WB
  always_comb begin
    eop_c    = 2'b00;
    aluop_c  = 2'b00;
    alusrc_c = 1'b0;
    if ((state_q == S_EXE) || (state_q == S_MEM) || (state_q == S_WB)) begin
      if (i_subu) begin
        aluop_c = 2'b01;
      end
      if (i_ori) begin
        aluop_c  = 2'b10;
        alusrc_c = 1'b1;
        eop_c    = 2'b00;
      end
      if (i_lui) begin
        aluop_c  = 2'b10;
        alusrc_c = 1'b1;
        eop_c    = 2'b10;
      end
      if (i_lw || i_sw) begin
        aluop_c  = 2'b00;
        alusrc_c = 1'b1;
        eop_c    = 2'b01;
      end
      if (i_beq) begin
        aluop_c = 2'b01;
        eop_c   = 2'b11;
      end
    end
  end

  // Next state, wait counter, event flags and per-state enables
  always_comb begin
    state_d    = state_q;
    cnt_d      = 8'd0;
    bus_err_d  = 1'b0;
    illegal_d  = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    iord_c     = 1'b0;
    irwr_c     = 1'b0;
    pcwr_c     = 1'b0;
    npcop_c    = 2'b00;
    regwr_c    = 1'b0;
    regdst_c   = 2'b00;
    memtoreg_c = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          irwr_c  = 1'b1;
          pcwr_c  = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          bus_err_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (i_goes_exe) begin
          state_d = S_EXE;
        end else if (i_j || i_jal) begin
          pcwr_c  = 1'b1;
          npcop_c = 2'b10;
          if (i_jal) begin
            regwr_c    = 1'b1;
            regdst_c   = 2'b10;
            memtoreg_c = 2'b10;
          end
          state_d = S_FETCH;
        end else if (i_jr) begin
          pcwr_c  = 1'b1;
          npcop_c = 2'b11;
          state_d = S_FETCH;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXE: begin
        if (i_beq) begin
          npcop_c = 2'b01;
          pcwr_c  = zero;
          state_d = S_FETCH;
        end else if (i_rarith || i_ori || i_lui) begin
          state_d = S_WB;
        end else if (i_lw || i_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_we_c  = i_sw;
        if (mem_ready) begin
          state_d = i_lw ? S_WB : S_FETCH;
        end else if (timed_out) begin
          bus_err_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        regwr_c = 1'b1;
        if (i_rarith) begin
          regdst_c = 2'b01;
        end
        if (i_lw) begin
          memtoreg_c = 2'b01;
        end
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and flag registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
    end
  end

  // Combinational outputs drop the instant reset asserts, so an in-flight
  // memory request or write enable never survives into reset.
  assign mem_req  = mem_req_c & reset;
  assign mem_we   = mem_we_c & reset;
  assign IorD     = iord_c & reset;
  assign IRWr     = irwr_c & reset;
  assign PCWr     = pcwr_c & reset;
  assign NPCOp    = npcop_c & {2{reset}};
  assign EOp      = eop_c & {2{reset}};
  assign ALUOp    = aluop_c & {2{reset}};
  assign ALUSrc   = alusrc_c & reset;
  assign RegWr    = regwr_c & reset;
  assign RegDst   = regdst_c & {2{reset}};
  assign MemtoReg = memtoreg_c & {2{reset}};
  assign bus_err  = bus_err_q;
  assign illegal  = illegal_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a table of per-cycle {inputs, expected outputs}
// records plus hand-written reset-in-MEM and handshake-timeout sequences.
module tb_mc_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_BAD  = 6'b111111;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, IorD, IRWr, PCWr, ALUSrc, RegWr, bus_err, illegal;
  logic [1:0] NPCOp, EOp, ALUOp, RegDst, MemtoReg;
  logic [2:0] state;

  mc_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
    .IRWr(IRWr), .PCWr(PCWr), .NPCOp(NPCOp), .EOp(EOp), .ALUOp(ALUOp),
    .ALUSrc(ALUSrc), .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .bus_err(bus_err), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed in the same order that exp_vec builds
  logic [21:0] obs;
  assign obs = {mem_req, mem_we, IorD, IRWr, PCWr, NPCOp, EOp, ALUOp, ALUSrc,
                RegWr, RegDst, MemtoReg, bus_err, illegal, state};

  function automatic logic [21:0] exp_vec(
    input int st, input int req, input int we, input int iord, input int irwr,
    input int pcwr, input int npc, input int eop, input int alu, input int asrc,
    input int rwr, input int rdst, input int m2r, input int berr, input int ill);
    return {req[0], we[0], iord[0], irwr[0], pcwr[0], npc[1:0], eop[1:0],
            alu[1:0], asrc[0], rwr[0], rdst[1:0], m2r[1:0], berr[0], ill[0],
            st[2:0]};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [21:0] exp;
    string       name;
  } vec_t;

  vec_t tab[64];
  int   n_vec;
  int   total;
  int   bad;

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input logic [21:0] ex, input string nm);
    tab[n_vec] = '{op, fn, z, rdy, ex, nm};
    n_vec++;
  endtask

  task automatic check(input logic [21:0] ex, input string nm);
    total++;
    if (obs !== ex) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, obs, ex);
    end else begin
      $display("ok   %s: %h", nm, obs);
    end
  endtask

  // One clock cycle: drive inputs, check settled outputs, advance past the edge
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic rdy, input logic [21:0] ex, input string nm);
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = rdy;
    #1;
    check(ex, nm);
    @(posedge clk);
    #1;
  endtask

  logic [21:0] v_zero, v_f1, v_f0, v_d0, v_ill, v_berr;
  logic [21:0] v_ldst_x, v_sw_m1, v_sw_m0, v_lw_m0, v_lw_m1;

  initial begin
    total = 0;
    bad   = 0;
    n_vec = 0;

    v_zero   = exp_vec(0, 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
    v_f1     = exp_vec(0, 1,0,0,1,1, 0,0,0,0, 0,0,0, 0,0);
    v_f0     = exp_vec(0, 1,0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
    v_d0     = exp_vec(1, 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
    v_ill    = exp_vec(0, 1,0,0,1,1, 0,0,0,0, 0,0,0, 0,1);
    v_berr   = exp_vec(0, 1,0,0,0,0, 0,0,0,0, 0,0,0, 1,0);
    v_ldst_x = exp_vec(2, 0,0,0,0,0, 0,1,0,1, 0,0,0, 0,0);
    v_sw_m1  = exp_vec(3, 1,1,1,0,0, 0,1,0,1, 0,0,0, 0,0);
    v_sw_m0  = v_sw_m1;
    v_lw_m0  = exp_vec(3, 1,0,1,0,0, 0,1,0,1, 0,0,0, 0,0);
    v_lw_m1  = v_lw_m0;

    // Reset held with ready high: everything 0, state FETCH
    reset     = 1'b0;
    opcode    = OP_R;
    funct     = FN_ADDU;
    zero      = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check(v_zero, "reset_hold");
    reset = 1'b1;

    // addu: 0,1,2,4
    add(OP_R, FN_ADDU, 0, 1, v_f1, "addu_fetch");
    add(OP_R, FN_ADDU, 0, 1, v_d0, "addu_decode");
    add(OP_R, FN_ADDU, 0, 1, exp_vec(2, 0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0), "addu_exe");
    add(OP_R, FN_ADDU, 0, 1, exp_vec(4, 0,0,0,0,0, 0,0,0,0, 1,1,0, 0,0), "addu_wb");
    // subu
    add(OP_R, FN_SUBU, 0, 1, v_f1, "subu_fetch");
    add(OP_R, FN_SUBU, 0, 1, v_d0, "subu_decode");
    add(OP_R, FN_SUBU, 0, 1, exp_vec(2, 0,0,0,0,0, 0,0,1,0, 0,0,0, 0,0), "subu_exe");
    add(OP_R, FN_SUBU, 0, 1, exp_vec(4, 0,0,0,0,0, 0,0,1,0, 1,1,0, 0,0), "subu_wb");
    // ori with one fetch wait cycle
    add(OP_ORI, 6'd0, 0, 0, v_f0, "ori_fetch_wait");
    add(OP_ORI, 6'd0, 0, 1, v_f1, "ori_fetch");
    add(OP_ORI, 6'd0, 0, 1, v_d0, "ori_decode");
    add(OP_ORI, 6'd0, 0, 1, exp_vec(2, 0,0,0,0,0, 0,0,2,1, 0,0,0, 0,0), "ori_exe");
    add(OP_ORI, 6'd0, 0, 1, exp_vec(4, 0,0,0,0,0, 0,0,2,1, 1,0,0, 0,0), "ori_wb");
    // lui
    add(OP_LUI, 6'd0, 0, 1, v_f1, "lui_fetch");
    add(OP_LUI, 6'd0, 0, 1, v_d0, "lui_decode");
    add(OP_LUI, 6'd0, 0, 1, exp_vec(2, 0,0,0,0,0, 0,2,2,1, 0,0,0, 0,0), "lui_exe");
    add(OP_LUI, 6'd0, 0, 1, exp_vec(4, 0,0,0,0,0, 0,2,2,1, 1,0,0, 0,0), "lui_wb");
    // sw zero-wait
    add(OP_SW, 6'd0, 0, 1, v_f1, "sw_fetch");
    add(OP_SW, 6'd0, 0, 1, v_d0, "sw_decode");
    add(OP_SW, 6'd0, 0, 1, v_ldst_x, "sw_exe");
    add(OP_SW, 6'd0, 0, 1, v_sw_m1, "sw_mem");
    // lw with ready low for 3 cycles in MEM
    add(OP_LW, 6'd0, 0, 1, v_f1, "lw_fetch");
    add(OP_LW, 6'd0, 0, 1, v_d0, "lw_decode");
    add(OP_LW, 6'd0, 0, 1, v_ldst_x, "lw_exe");
    add(OP_LW, 6'd0, 0, 0, v_lw_m0, "lw_mem_wait0");
    add(OP_LW, 6'd0, 0, 0, v_lw_m0, "lw_mem_wait1");
    add(OP_LW, 6'd0, 0, 0, v_lw_m0, "lw_mem_wait2");
    add(OP_LW, 6'd0, 0, 1, v_lw_m1, "lw_mem_done");
    add(OP_LW, 6'd0, 0, 1, exp_vec(4, 0,0,0,0,0, 0,1,0,1, 1,0,1, 0,0), "lw_wb");
    // beq taken and not taken
    add(OP_BEQ, 6'd0, 1, 1, v_f1, "beq1_fetch");
    add(OP_BEQ, 6'd0, 1, 1, v_d0, "beq1_decode");
    add(OP_BEQ, 6'd0, 1, 1, exp_vec(2, 0,0,0,0,1, 1,3,1,0, 0,0,0, 0,0), "beq1_exe");
    add(OP_BEQ, 6'd0, 0, 1, v_f1, "beq0_fetch");
    add(OP_BEQ, 6'd0, 0, 1, v_d0, "beq0_decode");
    add(OP_BEQ, 6'd0, 0, 1, exp_vec(2, 0,0,0,0,0, 1,3,1,0, 0,0,0, 0,0), "beq0_exe");
    // jumps
    add(OP_J, 6'd0, 0, 1, v_f1, "j_fetch");
    add(OP_J, 6'd0, 0, 1, exp_vec(1, 0,0,0,0,1, 2,0,0,0, 0,0,0, 0,0), "j_decode");
    add(OP_JAL, 6'd0, 0, 1, v_f1, "jal_fetch");
    add(OP_JAL, 6'd0, 0, 1, exp_vec(1, 0,0,0,0,1, 2,0,0,0, 1,2,2, 0,0), "jal_decode");
    add(OP_R, FN_JR, 0, 1, v_f1, "jr_fetch");
    add(OP_R, FN_JR, 0, 1, exp_vec(1, 0,0,0,0,1, 3,0,0,0, 0,0,0, 0,0), "jr_decode");
    // illegal opcode, then illegal R funct
    add(OP_BAD, 6'd0, 0, 1, v_f1, "bad_op_fetch");
    add(OP_BAD, 6'd0, 0, 1, v_d0, "bad_op_decode");
    add(OP_R, FN_BAD, 0, 1, v_ill, "bad_fn_fetch_ill");
    add(OP_R, FN_BAD, 0, 1, v_d0, "bad_fn_decode");
    add(OP_J, 6'd0, 0, 0, exp_vec(0, 1,0,0,0,0, 0,0,0,0, 0,0,0, 0,1), "after_bad_fn_ill");
    add(OP_J, 6'd0, 0, 1, v_f1, "after_ill_clear");
    add(OP_J, 6'd0, 0, 1, exp_vec(1, 0,0,0,0,1, 2,0,0,0, 0,0,0, 0,0), "j2_decode");

    for (int i = 0; i < n_vec; i++) begin
      step(tab[i].op, tab[i].fn, tab[i].z, tab[i].rdy, tab[i].exp, tab[i].name);
    end

    // Reset asserted during a stalled sw MEM cycle
    step(OP_SW, 6'd0, 0, 1, v_f1, "rst_sw_fetch");
    step(OP_SW, 6'd0, 0, 1, v_d0, "rst_sw_decode");
    step(OP_SW, 6'd0, 0, 1, v_ldst_x, "rst_sw_exe");
    mem_ready = 1'b0;
    #1;
    check(v_sw_m0, "rst_sw_mem_before");
    reset = 1'b0;
    #1;
    check(v_zero, "rst_async_drop");
    @(posedge clk);
    #1;
    check(v_zero, "rst_held");
    reset = 1'b1;

    // Fetch never answered: 16 waiting cycles, then bus_err in FETCH
    for (int i = 0; i < 16; i++) begin
      step(OP_J, 6'd0, 0, 0, v_f0, $sformatf("to_wait%0d", i));
    end
    step(OP_J, 6'd0, 0, 0, v_berr, "to_bus_err");
    // Counter restarted at 0: ready arriving exactly at count==TIMEOUT succeeds
    for (int i = 1; i < 15; i++) begin
      step(OP_J, 6'd0, 0, 0, v_f0, $sformatf("to2_wait%0d", i));
    end
    step(OP_J, 6'd0, 0, 1, v_f1, "to2_ready_at_limit");
    step(OP_J, 6'd0, 0, 1, exp_vec(1, 0,0,0,0,1, 2,0,0,0, 0,0,0, 0,0), "to2_j_decode");
    step(OP_J, 6'd0, 0, 0, v_f0, "to2_back_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
